fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 131 +++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch front end: issues one word-aligned request at a time to
// instruction memory and queues returned words with their PCs for decode.
module fetch_unit #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    input  logic        flush,
    output logic        pc_advance,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DISCARD
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   count;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [31:0]        req_pc;
    logic [31:0]        buf_instr [DEPTH];
    logic [31:0]        buf_pc    [DEPTH];

    logic push;
    logic pop;
    logic pc_lsb_unused;

    // The byte offset of the PC never reaches memory; fetches are whole words.
    assign pc_lsb_unused = ^pc[1:0];
    assign imem_addr     = {pc[31:2], 2'b00};

    // Gating with rst keeps the request low while reset is held, yet lets the
    // first request rise in the very cycle reset is released.
    assign imem_req    = rst && (state == IDLE) && (count < FULL) && !flush;
    assign pc_advance  = imem_req && imem_gnt;

    assign instr_valid = (count != '0) && !flush;
    assign instr       = buf_instr[rd_ptr];
    assign instr_pc    = buf_pc[rd_ptr];

    assign push = (state == WAIT) && imem_rvalid && !flush;
    assign pop  = instr_valid && instr_ready;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            req_pc <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pc_advance) begin
                        state  <= WAIT;
                        req_pc <= imem_addr;
                    end
                end
                WAIT: begin
                    if (flush) begin
                        state <= imem_rvalid ? IDLE : DISCARD;
                    end else if (imem_rvalid) begin
                        state <= IDLE;
                    end
                end
                DISCARD: begin
                    // The response retires the stale request even if another
                    // flush lands on it; waiting longer would never end.
                    if (imem_rvalid) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // NOTE: the buffer storage is reset on purpose so instr and instr_pc read
    // as zero while reset is held; a plain RAM here would expose garbage.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                buf_instr[i] <= '0;
                buf_pc[i]    <= '0;
            end
        end else if (push) begin
            buf_instr[wr_ptr] <= imem_rdata;
            buf_pc[wr_ptr]    <= req_pc;
        end
    end

endmodule
